// File: rtl/serial_shifter_pkg.sv
// Shared types and constants for the serial shift unit.
package serial_shifter_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/serial_shifter_if.sv
// Request/response handshake bundle between operand fetch, the shift unit and writeback.
interface serial_shifter_if
    import serial_shifter_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op;
    logic [XLEN-1:0]    operand;
    logic [SHAMT_W-1:0] shamt;
    logic               kill;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    result;

    modport master (
        output in_valid, op, operand, shamt, kill, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, operand, shamt, kill, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/serial_shifter_shift_step.sv
// One shift step of the data register with SLL/SRL/SRA fill.
// SERIAL_SHIFTER_STEP4_EN adds the 4-bit step path and its select input.
module shift_step
    import serial_shifter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_op,
`ifdef SERIAL_SHIFTER_STEP4_EN
    input  logic            i_step4,
`endif
    output logic [XLEN-1:0] o_data
);
    logic            w_right;
    logic            w_fill;
    logic [XLEN-1:0] w_step1;

    // Reserved op 10 has bit 0 clear, so it falls onto the left-shift path.
    assign w_right = i_op[0];
    assign w_fill  = (i_op == OP_SRA) & i_data[XLEN-1];
    assign w_step1 = w_right ? {w_fill, i_data[XLEN-1:1]} : {i_data[XLEN-2:0], 1'b0};

`ifdef SERIAL_SHIFTER_STEP4_EN
    logic [XLEN-1:0] w_step4;
    assign w_step4 = w_right ? {{4{w_fill}}, i_data[XLEN-1:4]} : {i_data[XLEN-5:0], 4'b0000};
    assign o_data  = i_step4 ? w_step4 : w_step1;
`else
    assign o_data  = w_step1;
`endif
endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle RV32I shift unit (SLL/SRL/SRA), one operation in flight.
// SERIAL_SHIFTER_STEP4_EN enables 4-bit steps while the remaining count is at least 4.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// SHIFT | stepping the data register, count counts down to zero
// DONE  | out_valid high, result held until out_ready
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_shifter_if.slave   bus
);
    state_e             r_state;
    state_e             w_state_nxt;
    logic [SHAMT_W-1:0] r_count;
    logic [1:0]         r_op;
    logic [XLEN-1:0]    r_data;
    logic [XLEN-1:0]    w_data_nxt;
    logic [SHAMT_W-1:0] w_dec;
    logic               w_last;
    logic               w_accept;

`ifdef SERIAL_SHIFTER_STEP4_EN
    logic w_step4;
    assign w_step4 = (r_count >= SHAMT_W'(4));
    assign w_dec   = w_step4 ? SHAMT_W'(4) : SHAMT_W'(1);
    assign w_last  = w_step4 ? (r_count == SHAMT_W'(4)) : (r_count == SHAMT_W'(1));

    shift_step #(.XLEN(XLEN)) u_step (
        .i_data  (r_data),
        .i_op    (r_op),
        .i_step4 (w_step4),
        .o_data  (w_data_nxt)
    );
`else
    assign w_dec  = SHAMT_W'(1);
    assign w_last = (r_count == SHAMT_W'(1));

    shift_step #(.XLEN(XLEN)) u_step (
        .i_data (r_data),
        .i_op   (r_op),
        .o_data (w_data_nxt)
    );
`endif

    // kill wins over a request in IDLE.
    assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.kill;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (bus.kill) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.kill || bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_op    <= OP_SLL;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data  <= bus.operand;
                        r_count <= bus.shamt;
                        r_op    <= bus.op;
                    end
                end
                SHIFT: begin
                    if (bus.kill) begin
                        r_count <= '0;
                    end else begin
                        r_data  <= w_data_nxt;
                        r_count <= r_count - w_dec;
                    end
                end
                DONE: begin
                    if (bus.kill) begin
                        r_count <= '0;
                    end
                end
                default: r_count <= '0;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_data;
endmodule
